// File: rtl/prod_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum_pkg
// Description : Shared types and default widths for the product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package prod_accum_pkg;

    // Default widths: a 16x16 multiplier feeds 32-bit products into a
    // 40-bit accumulator, giving 8 bits of guard headroom.
    localparam int PROD_W_DEFAULT = 32;
    localparam int ACC_W_DEFAULT  = 40;
    localparam int CNT_W_DEFAULT  = 8;

    // ST_ACC : collecting terms of the current sum
    // ST_HOLD: presenting a finished sum to the consumer
    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage : prod_accum_pkg
`default_nettype wire

// File: rtl/prod_accum_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : sat_add
// Description : W-bit unsigned adder with carry out. With PROD_ACCUM_SAT_EN
//               defined the result clamps to all-ones on carry; otherwise it
//               wraps modulo 2^W. The carry is reported in both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add
    import prod_accum_pkg::*;
#(
    parameter int W = ACC_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full;

    // One extra bit captures the carry; the result is clamped or wrapped.
    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[W];
`ifdef PROD_ACCUM_SAT_EN
        sum   = carry ? {W{1'b1}} : full[W-1:0];
`else
        sum   = full[W-1:0];
`endif
    end

endmodule : sat_add
`default_nettype wire

// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum
// Description : Accumulates a stream of unsigned products into a sum, counts
//               the terms and flags overflow. A beat with in_last closes the
//               sum, which is held on out_* until the consumer takes it.
//               Optional macro PROD_ACCUM_SAT_EN: saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEFAULT,
    parameter int ACC_W  = ACC_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    state_t             state;
    state_t             next_state;
    logic               armed;      // low in reset, high from the first edge after
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    logic               accept;
    logic               clr_now;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_base;
    logic [CNT_W-1:0]   cnt_base;
    logic               ovf_base;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_new;

    assign accept   = in_valid && in_ready;
    assign prod_ext = ACC_W'(in_product);

    // clr takes effect before a same-cycle beat, so the beat starts a new sum.
    assign clr_now  = clr && (state == ST_ACC);
    assign acc_base = clr_now ? '0 : acc;
    assign cnt_base = clr_now ? '0 : cnt;
    assign ovf_base = clr_now ? 1'b0 : ovf;

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a     (acc_base),
        .b     (prod_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Term counter sticks at all-ones instead of wrapping.
    assign cnt_inc = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
    assign ovf_new = ovf_base | add_carry;

    // Holds in_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) armed <= 1'b0;
        else     armed <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ACC;
        else     state <= next_state;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_ACC: begin
                in_ready = armed;
                if (in_valid && armed && in_last) next_state = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) next_state = ST_ACC;
            end
            default: next_state = ST_ACC;
        endcase
    end

    // Accumulator, counter, sticky overflow and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc <= add_sum;
                        cnt <= cnt_inc;
                        ovf <= ovf_new;
                        if (in_last) begin
                            out_sum <= add_sum;
                            out_cnt <= cnt_inc;
                            out_ovf <= ovf_new;
                        end
                    end else if (clr) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : prod_accum
`default_nettype wire

// File: tb/tb_prod_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_prod_accum
// Description : Self-checking bench for prod_accum. A default-width instance
//               and a 32-bit-accumulator instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prod_accum;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][31:0] t;
        logic [39:0]      esum;
        logic [7:0]       ecnt;
        logic             eovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_product;
    logic        in_last;
    logic        clr;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_ovf;
    logic [39:0] out_sum;
    logic [7:0]  out_cnt;
    logic        in_ready2, out_valid2, out_ovf2;
    logic [31:0] out_sum2;
    logic [7:0]  out_cnt2;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    prod_accum dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cnt    (out_cnt),
        .out_ovf    (out_ovf)
    );

    prod_accum #(.PROD_W(32), .ACC_W(32), .CNT_W(8)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_product (in_product),
        .in_last    (in_last),
        .clr        (clr),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_sum    (out_sum2),
        .out_cnt    (out_cnt2),
        .out_ovf    (out_ovf2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one beat, waiting (bounded) for in_ready; returns at posedge+1.
    task automatic send_beat(input logic [31:0] p, input logic last, input logic c);
        int w;
        w          = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        clr        = c;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("beat_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        clr        = 1'b0;
        in_product = '0;
    endtask

    // Sampled at the negedge right after the last-beat edge (latency 1).
    task automatic check_result(input string name, input logic [39:0] es,
                                input logic [7:0] ec, input logic eo);
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_sum"},   64'(out_sum),   64'(es));
        check({name, "_cnt"},   64'(out_cnt),   64'(ec));
        check({name, "_ovf"},   64'(out_ovf),   64'(eo));
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_ready_after"}, 64'(in_ready),  64'd1);
        check({name, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic add_vec(input int i, input logic [2:0] n, input logic [31:0] t0,
                           input logic [31:0] t1, input logic [31:0] t2, input logic [31:0] t3,
                           input logic [39:0] es, input logic [7:0] ec, input logic eo);
        vecs[i].n    = n;
        vecs[i].t[0] = t0;
        vecs[i].t[1] = t1;
        vecs[i].t[2] = t2;
        vecs[i].t[3] = t3;
        vecs[i].esum = es;
        vecs[i].ecnt = ec;
        vecs[i].eovf = eo;
    endtask

    initial begin
        logic [31:0] exp32;

        add_vec(0, 3, 32'd6, 32'd20, 32'd100, 32'd0, 40'd126, 8'd3, 1'b0);
        add_vec(1, 1, 32'hFFFE_0001, 32'd0, 32'd0, 32'd0, 40'hFF_FE00_01, 8'd1, 1'b0);
        add_vec(2, 4, 32'd1, 32'd2, 32'd3, 32'd4, 40'd10, 8'd4, 1'b0);
        add_vec(3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 40'h01_FFFF_FFFE, 8'd2, 1'b0);
        vecs[1].esum = 40'h00_FFFE_0001;

        rst = 1'b1; in_valid = 1'b0; in_product = '0; in_last = 1'b0;
        clr = 1'b0; out_ready = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cnt",   64'(out_cnt),   64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rel_ready_after_edge", 64'(in_ready), 64'd1);

        // Table-driven sums.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < int'(vecs[v].n); k++)
                send_beat(vecs[v].t[k], (k == int'(vecs[v].n) - 1), 1'b0);
            check_result($sformatf("vec%0d", v), vecs[v].esum, vecs[v].ecnt, vecs[v].eovf);
            handshake($sformatf("vec%0d", v));
        end

        // Consumer stalls 5 cycles: result stable, offered beats not taken.
        send_beat(32'd5, 1'b0, 1'b0);
        send_beat(32'd6, 1'b1, 1'b0);
        check_result("stall", 40'd11, 8'd2, 1'b0);
        in_valid = 1'b1; in_product = 32'd99; in_last = 1'b1; clr = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d_sum", c),   64'(out_sum),   64'd11);
            check($sformatf("stall%0d_cnt", c),   64'(out_cnt),   64'd2);
            check($sformatf("stall%0d_ready", c), 64'(in_ready),  64'd0);
        end
        in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; in_product = '0;
        handshake("stall");
        send_beat(32'd4, 1'b1, 1'b0);
        check_result("post_stall", 40'd4, 8'd1, 1'b0);
        handshake("post_stall");

        // Carry out of a 32-bit accumulator; the 40-bit one absorbs it.
`ifdef PROD_ACCUM_SAT_EN
        exp32 = 32'hFFFF_FFFF;
`else
        exp32 = 32'h0000_0001;
`endif
        send_beat(32'hFFFF_FFFF, 1'b0, 1'b0);
        send_beat(32'd2, 1'b1, 1'b0);
        check_result("ovf40", 40'h01_0000_0001, 8'd2, 1'b0);
        check("ovf32_sum", 64'(out_sum2), 64'(exp32));
        check("ovf32_ovf", 64'(out_ovf2), 64'd1);
        check("ovf32_cnt", 64'(out_cnt2), 64'd2);
        handshake("ovf");
        // Sticky flag must not leak into the next sum.
        send_beat(32'd8, 1'b1, 1'b0);
        check_result("after_ovf", 40'd8, 8'd1, 1'b0);
        check("after_ovf32_ovf", 64'(out_ovf2), 64'd0);
        check("after_ovf32_sum", 64'(out_sum2), 64'd8);
        handshake("after_ovf");

        // clr together with a beat: beat becomes the first term.
        send_beat(32'd7, 1'b0, 1'b0);
        send_beat(32'd9, 1'b0, 1'b0);
        send_beat(32'd5, 1'b1, 1'b1);
        check_result("clr", 40'd5, 8'd1, 1'b0);
        handshake("clr");

        // Term counter saturates at 255.
        for (int i = 0; i < 300; i++) send_beat(32'd1, (i == 299), 1'b0);
        check_result("cnt_sat", 40'd300, 8'd255, 1'b0);
        handshake("cnt_sat");

        // Asynchronous reset while holding a result.
        send_beat(32'd3, 1'b0, 1'b0);
        send_beat(32'd4, 1'b1, 1'b0);
        check_result("pre_rst", 40'd7, 8'd2, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_sum",   64'(out_sum),   64'd0);
        check("arst_ready", 64'(in_ready),  64'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_ready_after", 64'(in_ready), 64'd1);
        send_beat(32'd3, 1'b1, 1'b0);
        check_result("fresh", 40'd3, 8'd1, 1'b0);
        handshake("fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_prod_accum
`default_nettype wire
